// File: rtl/freelist_ckpt_if.sv
// rtl/freelist_ckpt_if.sv - dispatch/retire/checkpoint signal bundle for freelist_ckpt.
// master = dispatch/retire/branch side, slave = the free list.
interface freelist_ckpt_if #(
   parameter int ALLOC_WIDTH = 2,
   parameter int PR_COUNT    = 64,
   parameter int CKPT_DEPTH  = 4
);
   localparam int PR_IDX_W = $clog2(PR_COUNT);
   localparam int CNT_W    = $clog2(PR_COUNT + 1);
   localparam int CKPT_W   = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
   localparam int LANE_W   = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1;

   logic [ALLOC_WIDTH-1:0]          alloc_req;
   logic [ALLOC_WIDTH-1:0]          alloc_valid;
   logic [ALLOC_WIDTH*PR_IDX_W-1:0] alloc_tag;
   logic [ALLOC_WIDTH-1:0]          free_valid;
   logic [ALLOC_WIDTH*PR_IDX_W-1:0] free_tag;
   logic [CNT_W-1:0]                free_count;
   logic                            ckpt_save;
   logic [LANE_W-1:0]               ckpt_lane;
   logic [CKPT_W-1:0]               ckpt_id;
   logic                            ckpt_full;
   logic                            ckpt_release;
   logic                            ckpt_restore;
   logic [CKPT_W-1:0]               restore_id;

   modport master (
      output alloc_req, free_valid, free_tag, ckpt_save, ckpt_lane,
             ckpt_release, ckpt_restore, restore_id,
      input  alloc_valid, alloc_tag, free_count, ckpt_id, ckpt_full
   );

   modport slave (
      input  alloc_req, free_valid, free_tag, ckpt_save, ckpt_lane,
             ckpt_release, ckpt_restore, restore_id,
      output alloc_valid, alloc_tag, free_count, ckpt_id, ckpt_full
   );
endinterface

// File: rtl/freelist_ckpt.sv
// rtl/freelist_ckpt.sv - N-way physical-register free list with circular branch checkpoints.
// Optional FREELIST_FREE_BYPASS_EN: tags freed this cycle are grantable in the same cycle.
module freelist_ckpt #(
   parameter int ALLOC_WIDTH = 2,
   parameter int PR_COUNT    = 64,
   parameter int ARCH_COUNT  = 32,
   parameter int CKPT_DEPTH  = 4
) (
   input logic            clock,
   input logic            reset,
   freelist_ckpt_if.slave bus
);
   localparam int PR_IDX_W = $clog2(PR_COUNT);
   localparam int CNT_W    = $clog2(PR_COUNT + 1);
   localparam int CKPT_W   = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
   localparam int LIVE_W   = $clog2(CKPT_DEPTH + 1);

   typedef logic [PR_COUNT-1:0] vec_t;
   localparam vec_t RESET_VEC = ~((vec_t'(1) << ARCH_COUNT) - vec_t'(1));

   vec_t                free_vec, freed, granted, save_vec, next_vec;
   vec_t                grant_pref [ALLOC_WIDTH];
   vec_t                snap [CKPT_DEPTH];
   logic [CKPT_W-1:0]   head, tail, head_nx;
   logic [LIVE_W-1:0]   live_cnt, restore_live;
   logic [CKPT_DEPTH-1:0] live_mask;
   logic [CNT_W-1:0]    free_count_q;
   logic [ALLOC_WIDTH-1:0] valid_c;
   logic [PR_IDX_W-1:0] tag_c [ALLOC_WIDTH];
   logic                ckpt_full_c, save_ok, rel_ok, dup_free;

   function automatic logic [CKPT_W-1:0] ptr_inc(input logic [CKPT_W-1:0] p);
      return (p == CKPT_W'(CKPT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      freed    = '0;
      dup_free = 1'b0;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         if (bus.free_valid[i])
            freed[bus.free_tag[i*PR_IDX_W +: PR_IDX_W]] = 1'b1;
         for (int j = i + 1; j < ALLOC_WIDTH; j++)
            if (bus.free_valid[i] && bus.free_valid[j] &&
                bus.free_tag[i*PR_IDX_W +: PR_IDX_W] == bus.free_tag[j*PR_IDX_W +: PR_IDX_W])
               dup_free = 1'b1;
      end
   end

   // Lane-ordered lowest-index search; an exhausted pool leaves every later lane ungranted.
   always_comb begin
      vec_t avail, late;
      logic found;
      avail = free_vec;
`ifdef FREELIST_FREE_BYPASS_EN
      late  = freed & ~free_vec;
`else
      late  = '0;
`endif
      found   = 1'b0;
      granted = '0;
      valid_c = '0;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         tag_c[i] = '0;
         found    = 1'b0;
         if (bus.alloc_req[i]) begin
            for (int j = 0; j < PR_COUNT; j++)
               if (!found && avail[j]) begin
                  found = 1'b1; tag_c[i] = PR_IDX_W'(j); avail[j] = 1'b0; granted[j] = 1'b1;
               end
            for (int j = 0; j < PR_COUNT; j++)
               if (!found && late[j]) begin
                  found = 1'b1; tag_c[i] = PR_IDX_W'(j); late[j] = 1'b0; granted[j] = 1'b1;
               end
         end
         valid_c[i]    = found;
         grant_pref[i] = granted;
      end
   end

   always_comb begin
      for (int i = 0; i < ALLOC_WIDTH; i++)
         bus.alloc_tag[i*PR_IDX_W +: PR_IDX_W] = tag_c[i];
      bus.alloc_valid = (reset || bus.ckpt_restore) ? '0 : valid_c;
   end

   always_comb begin
`ifdef FREELIST_FREE_BYPASS_EN
      next_vec = (free_vec | freed) & ~granted;
      save_vec = (free_vec | freed) & ~grant_pref[bus.ckpt_lane];
`else
      next_vec = (free_vec & ~granted) | freed;
      save_vec = (free_vec & ~grant_pref[bus.ckpt_lane]) | freed;
`endif
      if (bus.ckpt_restore)
         next_vec = snap[bus.restore_id] | freed;
   end

   // Live slots run from head for live_cnt entries, wrapping modulo CKPT_DEPTH.
   always_comb begin
      int off, rl;
      off         = 0;
      rl          = 0;
      ckpt_full_c = (live_cnt == LIVE_W'(CKPT_DEPTH));
      save_ok     = bus.ckpt_save && !ckpt_full_c && !bus.ckpt_restore;
      rel_ok      = bus.ckpt_release && (live_cnt != '0);
      head_nx     = rel_ok ? ptr_inc(head) : head;
      live_mask   = '0;
      for (int k = 0; k < CKPT_DEPTH; k++) begin
         off = k - int'(head);
         if (off < 0) off = off + CKPT_DEPTH;
         live_mask[k] = (off < int'(live_cnt));
      end
      rl = int'(bus.restore_id) - int'(head_nx);
      if (rl < 0) rl = rl + CKPT_DEPTH;
      restore_live = LIVE_W'(rl);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_vec     <= RESET_VEC;
         free_count_q <= CNT_W'(PR_COUNT - ARCH_COUNT);
         head         <= '0;
         tail         <= '0;
         live_cnt     <= '0;
         for (int k = 0; k < CKPT_DEPTH; k++) snap[k] <= '0;
      end else begin
         free_vec     <= next_vec;
         free_count_q <= CNT_W'($countones(next_vec));
         for (int k = 0; k < CKPT_DEPTH; k++) begin
            if (save_ok && tail == CKPT_W'(k))
               snap[k] <= save_vec;
            else if (live_mask[k])
               snap[k] <= snap[k] | freed;
         end
         head <= head_nx;
         if (bus.ckpt_restore) begin
            tail     <= bus.restore_id;
            live_cnt <= restore_live;
         end else begin
            tail     <= save_ok ? ptr_inc(tail) : tail;
            live_cnt <= live_cnt + LIVE_W'(save_ok) - LIVE_W'(rel_ok);
         end
      end
   end

   assign bus.free_count = free_count_q;
   assign bus.ckpt_id    = tail;
   assign bus.ckpt_full  = ckpt_full_c;

   always @(posedge clock) begin
      if (!reset) begin
         assert (!(bus.ckpt_save && !bus.ckpt_restore && ckpt_full_c))
            else $error("freelist_ckpt: save while all checkpoint slots live");
         assert (!(bus.ckpt_release && live_cnt == '0))
            else $error("freelist_ckpt: release with no live checkpoint");
         assert (!(bus.ckpt_release && bus.ckpt_restore && bus.restore_id == head))
            else $error("freelist_ckpt: restore of head slot while releasing it");
         assert (((freed & free_vec) == '0) && !dup_free)
            else $error("freelist_ckpt: tag freed twice");
      end
   end
endmodule

// File: tb/tb_freelist_ckpt.sv
// tb/tb_freelist_ckpt.sv - directed and randomized checks of freelist_ckpt against a set/queue model.
module tb_freelist_ckpt;
   localparam int N = 2, PR = 64, ARCH = 32, D = 4;
`ifdef FREELIST_FREE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   freelist_ckpt_if #(.ALLOC_WIDTH(N), .PR_COUNT(PR), .CKPT_DEPTH(D)) bus ();
   freelist_ckpt #(.ALLOC_WIDTH(N), .PR_COUNT(PR), .ARCH_COUNT(ARCH), .CKPT_DEPTH(D)) dut (
      .clock(clock), .reset(reset), .bus(bus));

   int total = 0, bad = 0;

   logic [N-1:0] req, fv;
   int ftag [N];
   bit save, rel, rest;
   int lane, rid;

   bit [PR-1:0] mfree, mgrant, mgpref;
   bit [PR-1:0] msnap [D];
   int live_q [$];
   int mtail;
   bit mvalid [N];
   int mtag [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      req = '0; fv = '0; ftag[0] = 0; ftag[1] = 0;
      save = 0; rel = 0; rest = 0; lane = 0; rid = 0;
   endtask

   task automatic apply();
      bus.alloc_req    = req;
      bus.free_valid   = fv;
      bus.free_tag     = {6'(ftag[1]), 6'(ftag[0])};
      bus.ckpt_save    = save;
      bus.ckpt_lane    = 1'(lane);
      bus.ckpt_release = rel;
      bus.ckpt_restore = rest;
      bus.restore_id   = 2'(rid);
   endtask

   task automatic model_reset();
      mfree = {{(PR-ARCH){1'b1}}, {ARCH{1'b0}}};
      live_q.delete();
      mtail = 0;
   endtask

   // Candidates: free tags ascending, then (bypass build) freshly freed tags ascending.
   task automatic model_grant();
      int cand [$];
      bit [PR-1:0] late;
      late = '0;
      if (BYP)
         for (int i = 0; i < N; i++) if (fv[i] && !mfree[ftag[i]]) late[ftag[i]] = 1'b1;
      for (int t = 0; t < PR; t++) if (mfree[t]) cand.push_back(t);
      for (int t = 0; t < PR; t++) if (late[t]) cand.push_back(t);
      mgrant = '0; mgpref = '0;
      for (int i = 0; i < N; i++) begin
         mvalid[i] = 0; mtag[i] = 0;
         if (req[i] && !rest && cand.size() > 0) begin
            mvalid[i] = 1; mtag[i] = cand.pop_front(); mgrant[mtag[i]] = 1'b1;
         end
         if (i == lane) mgpref = mgrant;
      end
   endtask

   task automatic model_update();
      bit [PR-1:0] freed, sv;
      bit save_ok, rel_ok;
      int idx;
      freed = '0;
      for (int i = 0; i < N; i++) if (fv[i]) freed[ftag[i]] = 1'b1;
      save_ok = save && !rest && live_q.size() < D;
      rel_ok  = rel && live_q.size() > 0;
      foreach (live_q[k]) msnap[live_q[k]] = msnap[live_q[k]] | freed;
      sv = BYP ? ((mfree | freed) & ~mgpref) : ((mfree & ~mgpref) | freed);
      if (rest)     mfree = msnap[rid] | freed;
      else if (BYP) mfree = (mfree | freed) & ~mgrant;
      else          mfree = (mfree & ~mgrant) | freed;
      if (save_ok) begin
         msnap[mtail] = sv; live_q.push_back(mtail); mtail = (mtail + 1) % D;
      end
      if (rel_ok) void'(live_q.pop_front());
      if (rest) begin
         idx = -1;
         foreach (live_q[k]) if (live_q[k] == rid && idx < 0) idx = k;
         if (idx >= 0) while (live_q.size() > idx) void'(live_q.pop_back());
         mtail = rid;
      end
   endtask

   task automatic peek();
      apply();
      #1;
   endtask

   task automatic tick();
      apply();
      model_grant();
      #1;
      chk("alloc_valid", bus.alloc_valid, {mvalid[1], mvalid[0]});
      for (int i = 0; i < N; i++)
         if (mvalid[i]) chk("alloc_tag", bus.alloc_tag[i*6 +: 6], mtag[i]);
      chk("ckpt_id", bus.ckpt_id, mtail);
      chk("ckpt_full", bus.ckpt_full, live_q.size() == D);
      chk("free_count", bus.free_count, $countones(mfree));
      @(posedge clock);
      model_update();
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      clear_in(); req = 2'b11;
      peek();
      chk("rst_alloc_valid", bus.alloc_valid, 0);
      chk("rst_free_count", bus.free_count, PR - ARCH);
      chk("rst_ckpt_id", bus.ckpt_id, 0);
      chk("rst_ckpt_full", bus.ckpt_full, 0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      clear_in(); apply();
   endtask

   initial begin
      int alloc_q [$];
      int pick;
      clear_in(); apply(); model_reset();

      // Basic grants and registered free_count.
      do_reset();
      req = 2'b11; peek();
      chk("first_tag0", bus.alloc_tag[5:0], 32);
      chk("first_tag1", bus.alloc_tag[11:6], 33);
      chk("first_count", bus.free_count, 32);
      tick();
      peek();
      chk("second_tag0", bus.alloc_tag[5:0], 34);
      chk("second_tag1", bus.alloc_tag[11:6], 35);
      chk("second_count", bus.free_count, 30);
      tick();
      peek();
      chk("third_count", bus.free_count, 28);
      for (int c = 0; c < 13; c++) tick();
      req = 2'b01; tick();
      req = 2'b11; peek();
      chk("prefix_valid", bus.alloc_valid, 2'b01);
      chk("prefix_tag", bus.alloc_tag[5:0], 63);
      tick();
      // Zero free: a tag freed now is only grantable this cycle in the bypass build.
      req = 2'b01; fv = 2'b01; ftag[0] = 5; peek();
      chk("bypass_valid", bus.alloc_valid, BYP ? 2'b01 : 2'b00);
      tick();
      clear_in(); req = 2'b10; peek();
      chk("lane1_valid", bus.alloc_valid, BYP ? 2'b00 : 2'b10);
      tick();

      // Checkpoint taken mid-bundle, then restored.
      do_reset();
      req = 2'b11; save = 1; lane = 0; tick();
      clear_in(); req = 2'b01; peek();
      chk("post_save_tag", bus.alloc_tag[5:0], 34);
      tick();
      clear_in(); req = 2'b11; rest = 1; rid = 0; peek();
      chk("restore_blocks", bus.alloc_valid, 0);
      tick();
      clear_in(); req = 2'b11; peek();
      chk("restored_count", bus.free_count, 31);
      chk("restored_tag0", bus.alloc_tag[5:0], 33);
      chk("restored_tag1", bus.alloc_tag[11:6], 34);
      tick();

      // A retired tag survives a restore of an older snapshot.
      clear_in(); save = 1; tick();
      clear_in(); fv = 2'b01; ftag[0] = 5; tick();
      clear_in(); rest = 1; rid = 0; tick();
      clear_in(); req = 2'b01; peek();
      chk("retired_count", bus.free_count, 30);
      chk("retired_tag", bus.alloc_tag[5:0], 5);
      tick();

      // Fill all slots, then release + restore in one cycle.
      for (int s = 0; s < D; s++) begin
         clear_in(); save = 1; peek();
         chk("save_id", bus.ckpt_id, s);
         tick();
      end
      clear_in(); rel = 1; rest = 1; rid = 2; peek();
      chk("full_flag", bus.ckpt_full, 1);
      chk("full_id", bus.ckpt_id, 0);
      tick();
      clear_in(); peek();
      chk("rr_id", bus.ckpt_id, 2);
      chk("rr_full", bus.ckpt_full, 0);
      tick();
      clear_in(); rel = 1; tick();
      clear_in(); peek();
      chk("rr_empty_full", bus.ckpt_full, 0);
      tick();

      // Randomized traffic kept within the legal envelope.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         clear_in();
         req = 2'($urandom_range(0, 3));
         alloc_q.delete();
         for (int t = 0; t < PR; t++) if (!mfree[t]) alloc_q.push_back(t);
         for (int i = 0; i < N; i++)
            if (alloc_q.size() > 0 && $urandom_range(0, 9) < 4) begin
               pick = $urandom_range(0, alloc_q.size() - 1);
               fv[i] = 1'b1; ftag[i] = alloc_q[pick]; alloc_q.delete(pick);
            end
         rel = (live_q.size() > 0) && ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 9) == 0) begin
            if (rel && live_q.size() >= 2) begin
               rest = 1; rid = live_q[$urandom_range(1, live_q.size() - 1)];
            end else if (!rel && live_q.size() >= 1) begin
               rest = 1; rid = live_q[$urandom_range(0, live_q.size() - 1)];
            end
         end
         save = (live_q.size() < D || rest) && ($urandom_range(0, 3) == 0);
         lane = $urandom_range(0, 1);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
